// File: rtl/paddle_position_filter.sv
// paddle_position_filter
//
// Turns the raw 8-bit ADC sample stream into the paddle position used by the
// pong display block. Samples are averaged in fixed blocks, small changes are
// rejected by a deadband, the surviving average is mapped and clamped into the
// paddle range, and the result is only committed on a vertical sync falling
// edge so the paddle never tears mid-frame.
//
// Ports:
//   clk            system clock, shared with the VGA sync generator
//   reset          synchronous, active-high reset
//   adc_data       unsigned ADC sample
//   adc_valid      one sample accepted per high cycle
//   vga_v_sync     vertical sync, active low
//   PaddlePosition committed paddle position, always within PMIN..PMAX
//   frame_update   one-cycle pulse whenever PaddlePosition changes value

module paddle_position_filter #(
    parameter int LOG2N    = 4,
    parameter int SHIFT    = 5,
    parameter int PMIN     = 49,
    parameter int PMAX     = 56,
    parameter int DEADBAND = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] adc_data,
    input  logic       adc_valid,
    input  logic       vga_v_sync,
    output logic [7:0] PaddlePosition,
    output logic       frame_update
);

    localparam int ACC_W     = 8 + LOG2N;
    localparam int MID_POS   = PMIN + (128 >> SHIFT);
    localparam int RESET_POS = (MID_POS > PMAX) ? PMAX : MID_POS;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t state;
    state_t next_state;

    logic [ACC_W-1:0] acc;
    logic [LOG2N-1:0] cnt;
    logic [ACC_W-1:0] block_sum;
    logic [7:0]       avg_reg;
    logic             avg_new;
    logic [7:0]       accepted_avg;
    logic [7:0]       target;
    logic             vs_d;
    logic             vs_fall;

    logic signed [8:0] delta;
    logic [8:0]        delta_abs;
    logic [8:0]        mapped_sum;
    logic [7:0]        target_next;
    logic              accept;
    logic              commit;
    logic [7:0]        commit_value;

    // The last sample of a block is folded in directly so the next block can
    // start accumulating on the very next cycle.
    assign block_sum = acc + {{LOG2N{1'b0}}, adc_data};

    assign vs_fall = vs_d & ~vga_v_sync;

    // Deadband is measured against the last accepted average, not against the
    // committed position, so slow drift still accumulates into a change.
    assign delta     = $signed({1'b0, avg_reg}) - $signed({1'b0, accepted_avg});
    assign delta_abs = delta[8] ? 9'(-delta) : 9'(delta);
    assign accept    = avg_new && (delta_abs > 9'(DEADBAND));

    // Summed at 9 bits so the clamp sees any overflow past 255.
    assign mapped_sum  = 9'(PMIN) + 9'(avg_reg >> SHIFT);
    assign target_next = (mapped_sum > 9'(PMAX)) ? 8'(PMAX) : mapped_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            avg_reg <= '0;
            avg_new <= 1'b0;
        end else begin
            avg_new <= 1'b0;
            if (adc_valid) begin
                if (&cnt) begin
                    avg_reg <= 8'(block_sum >> LOG2N);
                    avg_new <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= block_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A filter accept coinciding with the sync edge bypasses straight to the
    // output, so the freshest target is never left waiting a whole frame.
    always_comb begin
        next_state   = state;
        commit       = 1'b0;
        commit_value = target;
        if (accept && vs_fall) begin
            commit       = 1'b1;
            commit_value = target_next;
            next_state   = IDLE;
        end else if ((state == PENDING) && vs_fall) begin
            commit     = 1'b1;
            next_state = IDLE;
        end else if (accept) begin
            next_state = PENDING;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            accepted_avg   <= 8'd128;
            target         <= 8'(RESET_POS);
            PaddlePosition <= 8'(RESET_POS);
            frame_update   <= 1'b0;
            vs_d           <= 1'b1;
        end else begin
            vs_d <= vga_v_sync;
            if (accept) begin
                accepted_avg <= avg_reg;
                target       <= target_next;
            end
            frame_update <= commit && (commit_value != PaddlePosition);
            if (commit) begin
                PaddlePosition <= commit_value;
            end
        end
    end

endmodule
